// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 bit voting in the sampler).
package uart_pkg;

    typedef enum logic [1:0] {
        ParityNone = 2'd0,
        ParityOdd  = 2'd1,
        ParityEven = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic brk;
    } rx_flags_t;

    // Width of the per-bit clock counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser and bit sampler for uart_rx_framed.
// With UART_RX_MAJORITY_EN defined each bit is a 2-of-3 vote decided one cycle
// after the nominal sample point; otherwise a single sample is taken at the point.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned CntW         = cnt_width(CLKS_PER_BIT)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            rx_serial_i,
    input  logic            in_start_i,
    input  logic [CntW-1:0] cnt_i,
    output logic            line_o,
    output logic            strobe_o,
    output logic            bit_o
);
    localparam int unsigned Half = (CLKS_PER_BIT - 1) / 2;

    logic sync1_q, sync2_q;

    // Two-flop synchroniser, idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial_i;
            sync2_q <= sync1_q;
        end
    end

    assign line_o = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    logic hist1_q, hist2_q;

    // History of the synchronised line for the three-sample vote.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // Decide at point+1; the whole frame then runs one cycle late, so later bits
    // still decide at CLKS_PER_BIT-1 of their own counter.
    always_comb begin
        strobe_o = in_start_i ? (cnt_i == CntW'(Half + 1))
                              : (cnt_i == CntW'(CLKS_PER_BIT - 1));
        bit_o    = (hist2_q & hist1_q) | (hist2_q & sync2_q) | (hist1_q & sync2_q);
    end
`else
    // Single sample at the nominal point.
    always_comb begin
        strobe_o = in_start_i ? (cnt_i == CntW'(Half))
                              : (cnt_i == CntW'(CLKS_PER_BIT - 1));
        bit_o    = sync2_q;
    end
`endif

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with parity/framing/break/overrun detection and a
// one-entry valid/ready holding register.
// Optional build macro: UART_RX_MAJORITY_EN (see uart_rx_sampler).
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_serial_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_break_o,
    output logic                 rx_overrun_o,
    output logic                 rx_busy_o
);
    localparam int unsigned  CntW     = cnt_width(CLKS_PER_BIT);
    localparam parity_mode_e ParMode  = parity_mode_e'(PARITY_MODE[1:0]);
    localparam bit           ParityEn = (ParMode != ParityNone);
    localparam bit           OddSel   = (ParMode == ParityOdd);

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 fe_q, fe_d;
    logic                 brk_q, brk_d;
    logic                 brk_wait_q, brk_wait_d;
    logic                 frame_done;

    logic [DATA_BITS-1:0] data_q, data_d;
    rx_flags_t            flags_q, flags_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;

    logic line, strobe, samp;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CntW        (CntW)
    ) u_sampler (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rx_serial_i(rx_serial_i),
        .in_start_i (state_q == StStart),
        .cnt_i      (cnt_q),
        .line_o     (line),
        .strobe_o   (strobe),
        .bit_o      (samp)
    );

    // Frame FSM: walks start/data/parity/stop and accumulates data and flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;
        fe_d       = fe_q;
        brk_d      = brk_q;
        brk_wait_d = brk_wait_q;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (brk_wait_q) begin
                    // A break leaves the line low; only re-arm once it has recovered.
                    if (line) brk_wait_d = 1'b0;
                end else if (!line) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (strobe) begin
                    cnt_d = '0;
                    if (!samp) begin
                        state_d = StData;
                        idx_d   = '0;
                        par_d   = 1'b0;
                        fe_d    = 1'b0;
                        brk_d   = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (strobe) begin
                    cnt_d   = '0;
                    shift_d = {samp, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        state_d    = ParityEn ? StParity : StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (strobe) begin
                    cnt_d      = '0;
                    par_d      = samp;
                    stop_idx_d = 1'b0;
                    state_d    = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (strobe) begin
                    cnt_d = '0;
                    fe_d  = fe_q | ~samp;
                    if (!stop_idx_q && !samp && (shift_q == '0) && !par_q) brk_d = 1'b1;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // Leave at the sample so a following start bit is not missed.
                        state_d    = StIdle;
                        frame_done = 1'b1;
                        brk_wait_d = brk_d;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register: load on completion unless full and not being read.
    always_comb begin
        data_d  = data_q;
        flags_d = flags_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (frame_done) begin
            if (!valid_q || rx_ready_i) begin
                data_d             = shift_q;
                flags_d.parity_err = ParityEn && ((^shift_q ^ par_q) != OddSel);
                flags_d.frame_err  = fe_d;
                flags_d.brk        = brk_d;
                valid_d            = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and holding-register flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            brk_wait_q <= 1'b0;
            data_q     <= '0;
            flags_q    <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            brk_wait_q <= brk_wait_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign rx_parity_err_o = flags_q.parity_err;
    assign rx_frame_err_o  = flags_q.frame_err;
    assign rx_break_o      = flags_q.brk;
    assign rx_overrun_o    = ovr_q;
    assign rx_busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: directed frames with literal expectations plus
// randomized frames, all checked every cycle against a frame-level model.
module tb_uart_rx_framed;
    localparam int unsigned CPB  = 16;
    localparam int unsigned DB   = 8;
    localparam int unsigned PM   = 2;
    localparam int unsigned SB   = 2;
    localparam int unsigned HALF = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MAJ = 1;
`else
    localparam int unsigned MAJ = 0;
`endif
    localparam int unsigned NBITS = DB + ((PM != 0) ? 1 : 0) + SB;
    // Start edge on the pin to rx_valid_o: 2 sync + 1 idle detect + half bit +
    // NBITS full bits + 1 load cycle.
    localparam int unsigned LAT = 4 + HALF + NBITS * CPB + MAJ;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_line = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_pe, rx_fe, rx_brk, rx_ovr, rx_busy;

    uart_rx_framed #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY_MODE (PM),
        .STOP_BITS   (SB)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_serial_i    (rx_line),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .rx_parity_err_o(rx_pe),
        .rx_frame_err_o (rx_fe),
        .rx_break_o     (rx_brk),
        .rx_overrun_o   (rx_ovr),
        .rx_busy_o      (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int ovr_seen = 0;

    typedef struct {
        int unsigned   t;
        logic [DB-1:0] d;
        logic          pe;
        logic          fe;
        logic          brk;
    } exp_t;

    exp_t          q[$];
    logic          m_valid = 1'b0;
    logic [DB-1:0] m_d = '0;
    logic          m_pe = 1'b0, m_fe = 1'b0, m_brk = 1'b0, m_ovr = 1'b0, m_fire;
    bit            rand_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Expected outcome of a frame from what was put on the wire.
    function automatic exp_t mk_exp(input logic [DB-1:0] d, input logic p,
                                    input logic s0, input logic s1);
        exp_t e;
        int   ones = $countones(d) + ((PM != 0) ? int'(p) : 0);
        e.t   = 0;
        e.d   = d;
        e.pe  = (PM == 2) ? (ones % 2 == 1) : (PM == 1) ? (ones % 2 == 0) : 1'b0;
        e.brk = (d == '0) && (PM == 0 || !p) && !s0;
        e.fe  = !s0 || (SB == 2 && !s1);
        return e;
    endfunction

    // Holding-register model: frames arrive at precomputed cycles.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                q.delete();
            end else begin
                m_fire = m_valid && rx_ready;
                m_ovr  = 1'b0;
                if (q.size() != 0 && q[0].t == cyc + 1) begin
                    if (!m_valid || m_fire) begin
                        m_valid = 1'b1;
                        m_d     = q[0].d;
                        m_pe    = q[0].pe;
                        m_fe    = q[0].fe;
                        m_brk   = q[0].brk;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    void'(q.pop_front());
                end else if (m_fire) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", rx_valid, m_valid);
            chk("overrun", rx_ovr, m_ovr);
            if (rx_ovr) ovr_seen++;
            if (m_valid) begin
                chk("data", rx_data, m_d);
                chk("parity_err", rx_pe, m_pe);
                chk("frame_err", rx_fe, m_fe);
                chk("break", rx_brk, m_brk);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx_line = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s0,
                              input logic s1, input bit push);
        exp_t e;
        rx_line = 1'b0;
        if (push) begin
            e   = mk_exp(d, p, s0, s1);
            e.t = cyc + LAT;
            q.push_back(e);
        end
        repeat (CPB) tick();
        for (int i = 0; i < int'(DB); i++) hold_bit(d[i]);
        if (PM != 0) hold_bit(p);
        hold_bit(s0);
        if (SB == 2) hold_bit(s1);
        rx_line = 1'b1;
    endtask

    task automatic wait_valid(input string name, input logic [DB-1:0] d, input logic pe,
                              input logic fe, input logic brk);
        int n = 0;
        @(negedge clk);
        while (!rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            total++;
            bad++;
            $display("FAIL %s: rx_valid_o stayed 0, required 1 within 400 cycles", name);
        end else begin
            chk({name, "_data"}, rx_data, d);
            chk({name, "_pe"}, rx_pe, pe);
            chk({name, "_fe"}, rx_fe, fe);
            chk({name, "_brk"}, rx_brk, brk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        int          ovr_base;
        exp_t        e;

        // Reset state.
        repeat (3) tick();
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, '0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_flags", {rx_pe, rx_fe, rx_brk, rx_ovr}, 4'b0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Clean frame, correct even parity (0xAB has five ones -> parity 1).
        fork
            send_frame(8'hAB, 1'b1, 1'b1, 1'b1, 1'b1);
            begin
                wait_valid("ab", 8'hAB, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                chk("ab_pulse_len", rx_valid, 1'b0);
            end
        join
        repeat (CPB) tick();

        // Wrong then right parity on 0x5A (four ones -> parity 0).
        fork
            send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
            wait_valid("5a_bad", 8'h5A, 1'b1, 1'b0, 1'b0);
        join
        repeat (CPB) tick();
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_valid("5a_good", 8'h5A, 1'b0, 1'b0, 1'b0);
        join
        repeat (CPB) tick();

        // Second stop bit low.
        fork
            send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
            wait_valid("stop2", 8'h3C, 1'b0, 1'b1, 1'b0);
        join
        repeat (2 * CPB) tick();

        // Break: line low for 14 bit periods gives exactly one frame.
        rx_line = 1'b0;
        e       = mk_exp('0, 1'b0, 1'b0, 1'b0);
        e.t     = cyc + LAT;
        q.push_back(e);
        fork
            repeat (14 * CPB) tick();
            wait_valid("break", 8'h00, 1'b0, 1'b1, 1'b1);
        join
        chk("break_wait_busy", rx_busy, 1'b0);
        rx_line = 1'b1;
        repeat (3 * CPB) tick();

        // Overrun: two back-to-back frames with the consumer stalled.
        rx_ready = 1'b0;
        ovr_base = ovr_seen;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (CPB) tick();
        chk("ovr_pulses", ovr_seen - ovr_base, 1);
        chk("ovr_held_valid", rx_valid, 1'b1);
        chk("ovr_held_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ovr_drain", rx_valid, 1'b0);
        repeat (4 * CPB) tick();

        // Start glitch of three clocks is rejected after the half-bit check.
        k       = cyc;
        rx_line = 1'b0;
        repeat (3) tick();
        rx_line = 1'b1;
        chk("glitch_busy_on", rx_busy, 1'b1);
        repeat (HALF + MAJ) tick();
        chk("glitch_busy_hold", rx_busy, 1'b1);
        tick();
        chk("glitch_busy_off", rx_busy, 1'b0);
        chk("glitch_cycles", cyc - k, 4 + HALF + MAJ);
        repeat (2 * CPB) tick();

        // Reset in the middle of the data bits, then a clean frame.
        rx_line = 1'b0;
        repeat (CPB) tick();
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        chk("mid_busy", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", rx_busy, 1'b0);
        chk("mid_rst_data", rx_data, '0);
        chk("mid_rst_out", {rx_valid, rx_pe, rx_fe, rx_brk, rx_ovr}, 5'b0);
        rx_line = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2 * CPB) tick();
        fork
            send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
            wait_valid("c3", 8'hC3, 1'b0, 1'b0, 1'b0);
        join
        repeat (CPB) tick();

        // Randomized frames with a mostly-stalled consumer.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [DB-1:0] d;
                    logic          p;
                    logic          s0;
                    d  = DB'($urandom);
                    if ($urandom_range(0, 7) == 0) d = '0;
                    p  = ($countones(d) % 2 == 1);
                    if ($urandom_range(0, 3) == 0) p = ~p;
                    s0 = ($urandom_range(0, 4) != 0);
                    send_frame(d, p, s0, 1'b1, 1'b1);
                    repeat ($urandom_range(0, CPB)) tick();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    rx_ready = ($urandom_range(0, 199) == 0);
                    tick();
                end
            end
        join
        rx_ready = 1'b1;
        repeat (LAT) tick();
        chk("queue_drained", q.size(), 0);
        chk("final_busy", rx_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity and stop bits, with framing, parity, break and overrun detection. A one-entry holding register with a valid/ready handshake sits between the serial line and the consumer, so back-pressure is visible as overrun instead of silent data loss.

Parameters:
CLKS_PER_BIT, 217, clocks per bit period (25 MHz / 115200); minimum 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
rx_serial_i  in  1  asynchronous serial line, idle high
rx_data_o  out  DATA_BITS  received data, LSB is the first bit on the line
rx_valid_o  out  1  holding register full
rx_ready_i  in  1  consumer accepts rx_data_o when rx_valid_o && rx_ready_i
rx_parity_err_o  out  1  parity error of held frame (valid with rx_valid_o)
rx_frame_err_o  out  1  a stop bit sampled low on held frame
rx_break_o  out  1  held frame was a break condition
rx_overrun_o  out  1  one-cycle pulse: completed frame dropped, register full
rx_busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - rx_data_o = 0; all flags 0; rx_valid_o = 0; rx_busy_o = 0.
  - FSM = IDLE; synchroniser flops = 1.
- Input synchroniser:
  - rx_serial_i passes through 2 flops before any use.
  - Reset drives mid-frame force IDLE and discard the partial frame.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - HALF = (CLKS_PER_BIT-1)/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Synchronised line low -> START, counter = 0.
- START:
  - Count to HALF, then sample.
  - Sample low -> DATA, counter = 0, bit index = 0.
  - Sample high -> IDLE (glitch rejection; no flags, no output).
- DATA:
  - Sample when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Shift in LSB first.
  - After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - One sample at the same point.
  - Error when XOR(data, parity bit) != (PARITY_MODE == 1).
- STOP:
  - STOP_BITS samples at the same point.
  - Any low sample sets the frame error.
  - After the last stop sample -> IDLE immediately; no wait for end of bit, which allows back-to-back frames.
- Break:
  - Condition: all data bits 0, the parity bit (if present) 0, and the first stop sample low.
  - Break also sets frame_err.
  - After a break, IDLE waits for the line to go high before arming start detection.
- Frame completion (cycle after the last stop sample):
  - Register empty, or being read in that same cycle: load data and flags; rx_valid_o = 1.
  - Register full and not read: drop the frame, pulse rx_overrun_o for 1 cycle, keep held data unchanged.
- Handshake:
  - rx_valid_o clears the cycle after rx_valid_o && rx_ready_i.
  - Simultaneous completion and read: new frame loaded, rx_valid_o stays 1, no overrun.
- Latency: the synchroniser adds 2 clk_i after the line edge; rx_valid_o rises 1 cycle after the last stop sample.

Optional Feature:
Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit (including start) is taken as a 2-of-3 majority of samples at counter values point-1, point, point+1, where point is HALF for start and CLKS_PER_BIT-1 for later bits.
  - The decision is made at point+1, so all timing shifts by +1 cycle.
  - Glitch rejection in START uses the voted value.
- Undefined: single sample at point; no extra flops.

Decomposition:
- Package uart_pkg:
  - parity_mode_e (NONE, ODD, EVEN) and rx_state_e.
  - Localparam helper for the counter width.
  - Flag struct {parity_err, frame_err, brk}.
- Sub-module uart_rx_sampler:
  - Contains the 2-flop synchroniser and the optional majority voter.
  - Outputs the synchronised line and a sample-strobe/value pair.
- The FSM, shift register and holding register live in uart_rx_framed.

Test Plan:
- 8N1, send 8'hAB with rx_ready_i=1 -> rx_valid_o one cycle, rx_data_o=8'hAB, all error flags 0.
- PARITY_MODE=2, 8'h5A sent with parity bit 1 (wrong) -> rx_data_o=8'h5A, rx_parity_err_o=1; repeat with parity 0 -> err 0.
- STOP_BITS=2, second stop bit driven low for 8'h3C -> rx_frame_err_o=1, rx_break_o=0, data 8'h3C.
- Line held low for 12 bit periods -> exactly one frame, rx_break_o=1, rx_frame_err_o=1, data 0; no second frame until the line returns high and a new start arrives.
- rx_ready_i=0, send 8'h11 then 8'h22 back-to-back -> held data 8'h11, one rx_overrun_o pulse; then ready=1 -> valid drops, no data 8'h22.
- Start glitch low for 3 clocks -> no rx_valid_o, rx_busy_o back to 0 after HALF+1 cycles; rst_n_i asserted mid-DATA -> all outputs 0 immediately, next clean 8'hC3 frame received correctly.
